// File: rtl/pulse_issue_queue.sv
// pulse_issue_queue: in-order timed issue queue between the pulse source and
// the pulse generator; holds each instruction until counter[15:0] reaches t_start.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pulse_inst_in[31:0]        {t_start[15:0], freq[3:0], phase[3:0], amp[7:0]}
//   pulse_inst_in_valid/ready  input handshake (ready low while full or flushing)
//   counter[31:0]              timebase, low 16 bits used for the due test
//   flush                      synchronous discard of FIFO and staged pulse
//   issue_valid/ready          output handshake to the generator
//   issue_t_start/freq/phase/amp, issue_late   staged pulse fields
//   late_count                 saturating count of late issues
//   occupancy, busy            FIFO count (+1 when staged), activity flag
module pulse_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH) + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pulse_inst_in,
  input  logic             pulse_inst_in_valid,
  output logic             pulse_inst_in_ready,
  input  logic [31:0]      counter,
  input  logic             flush,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [15:0]      issue_t_start,
  output logic [3:0]       issue_freq,
  output logic [3:0]       issue_phase,
  output logic [7:0]       issue_amp,
  output logic             issue_late,
  output logic [15:0]      late_count,
  output logic [OCC_W-1:0] occupancy,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FIRE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        fifo_empty;
  logic        push;
  logic        load;
  logic        fire;
  logic        hs;
  logic [15:0] diff;
  logic        due;
  logic [31:0] head;
  logic        unused_hi;

  assign unused_hi = ^counter[31:16];

  assign fifo_empty = (count == '0);
  assign pulse_inst_in_ready = (count != CW'(DEPTH)) && !flush;
  assign push = pulse_inst_in_valid && pulse_inst_in_ready;
  assign head = mem[rd_ptr];

  // Modulo-2^16 distance; the sign bit splits "not yet" from "due or past".
  assign diff = counter[15:0] - issue_t_start;
  assign due = !diff[15];

  assign hs = issue_valid && issue_ready && !flush;

  always_comb begin
    state_d = state_q;
    load = 1'b0;
    fire = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          load = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (due) begin
          fire = 1'b1;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        if (issue_ready) begin
          if (!fifo_empty) begin
            load = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      load = 1'b0;
      fire = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      issue_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_valid <= (state_d == S_FIRE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= pulse_inst_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_t_start <= '0;
      issue_freq <= '0;
      issue_phase <= '0;
      issue_amp <= '0;
    end else if (load) begin
      issue_t_start <= head[31:16];
      issue_freq <= head[15:12];
      issue_phase <= head[11:8];
      issue_amp <= head[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_late <= 1'b0;
    end else if (fire) begin
      issue_late <= (diff != 16'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      late_count <= '0;
    end else if (hs && issue_late && late_count != 16'hFFFF) begin
      late_count <= late_count + 16'd1;
    end
  end

  assign occupancy = OCC_W'(count) + OCC_W'(state_q != S_IDLE);
  assign busy = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pulse_issue_queue.sv
// tb_pulse_issue_queue: randomized scoreboard bench for pulse_issue_queue.
// Reference model tracks queue contents and per-pulse stage/fire times.
module tb_pulse_issue_queue;

  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH) + 2;
  localparam int SB = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      pin = '0;
  logic             pin_valid = 1'b0;
  logic             pin_ready;
  logic [31:0]      counter = '0;
  logic             flush = 1'b0;
  logic             issue_valid;
  logic             issue_ready = 1'b0;
  logic [15:0]      issue_t_start;
  logic [3:0]       issue_freq;
  logic [3:0]       issue_phase;
  logic [7:0]       issue_amp;
  logic             issue_late;
  logic [15:0]      late_count;
  logic [OCC_W-1:0] occupancy;
  logic             busy;

  pulse_issue_queue #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pulse_inst_in       (pin),
    .pulse_inst_in_valid (pin_valid),
    .pulse_inst_in_ready (pin_ready),
    .counter             (counter),
    .flush               (flush),
    .issue_valid         (issue_valid),
    .issue_ready         (issue_ready),
    .issue_t_start       (issue_t_start),
    .issue_freq          (issue_freq),
    .issue_phase         (issue_phase),
    .issue_amp           (issue_amp),
    .issue_late          (issue_late),
    .late_count          (late_count),
    .occupancy           (occupancy),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t;
    logic [3:0]  f;
    logic [3:0]  p;
    logic [7:0]  a;
    int          pe;
  } ent_t;

  typedef struct {
    logic [15:0] t;
    logic [3:0]  f;
    logic [3:0]  p;
    logic [7:0]  a;
    logic        late;
    int          edge_n;
  } rec_t;

  // Reference model state
  ent_t        mq[$];
  ent_t        ent;
  rec_t        rec [SB];
  int          wi = 0;
  int          cyc = 0;
  int          h_edge = 0;
  int          head_e = 0;
  int          head_fire = 0;
  logic        head_late = 1'b0;
  logic [15:0] m_late = '0;
  logic [15:0] diff;
  logic        staged;
  logic        firing;
  logic        acc;
  int          fcnt;
  logic        exp_valid = 1'b0;
  int          exp_occ = 0;
  int          exp_fcnt = 0;

  // Checker state
  int   tests = 0;
  int   fails = 0;
  int   ri = 0;
  logic seen = 1'b0;
  logic in_rst = 1'b0;
  rec_t cur;
  logic done = 1'b0;
  logic timed_out = 1'b0;

  // Each pulse becomes staged one edge after it is both queued and at the
  // front with the previous pulse gone; it then fires one edge after the
  // first cycle in which counter - t_start is non-negative (mod 2^16).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      mq.delete();
      h_edge = cyc;
      head_fire = 0;
      head_e = 0;
      m_late = '0;
    end else begin
      staged = (mq.size() > 0) && (head_e <= cyc - 1);
      firing = staged && (head_fire != 0) && (head_fire <= cyc - 1);
      fcnt = mq.size() - (staged ? 1 : 0);
      acc = pin_valid && (fcnt != DEPTH) && !flush;
      if (flush) begin
        mq.delete();
        h_edge = cyc;
        head_fire = 0;
      end else begin
        if (staged && head_fire == 0) begin
          diff = counter[15:0] - mq[0].t;
          if (!diff[15]) begin
            head_fire = cyc;
            head_late = (diff != 16'd0);
            rec[wi % SB] = '{mq[0].t, mq[0].f, mq[0].p, mq[0].a,
                             head_late, cyc};
            wi = wi + 1;
          end
        end
        if (firing && issue_ready) begin
          if (head_late && m_late != 16'hFFFF) m_late = m_late + 16'd1;
          void'(mq.pop_front());
          h_edge = cyc;
          head_fire = 0;
          if (mq.size() > 0) begin
            head_e = (mq[0].pe + 1 > cyc) ? mq[0].pe + 1 : cyc;
          end
        end
        if (acc) begin
          ent = '{pin[31:16], pin[15:12], pin[11:8], pin[7:0], cyc};
          if (mq.size() == 0) begin
            head_e = (cyc + 1 > h_edge) ? cyc + 1 : h_edge;
            head_fire = 0;
          end
          mq.push_back(ent);
        end
      end
    end
    staged = (mq.size() > 0) && (head_e <= cyc);
    exp_valid = staged && (head_fire != 0) && (head_fire <= cyc);
    exp_occ = mq.size();
    exp_fcnt = mq.size() - (staged ? 1 : 0);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: status every cycle, issued pulses popped from the scoreboard.
  initial begin
    while (!done) begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        if (!in_rst) begin
          #1;
          check("rst_issue_data",
                {issue_t_start, issue_freq, issue_phase, issue_amp}, 32'd0);
          check("rst_status",
                32'({issue_valid, issue_late, busy, late_count, occupancy}),
                32'd0);
          in_rst = 1'b1;
        end
        ri = wi;
        seen = 1'b0;
      end else begin
        in_rst = 1'b0;
        check("in_ready", 32'(pin_ready),
              32'((exp_fcnt != DEPTH) && !flush));
        check("issue_valid", 32'(issue_valid), 32'(exp_valid));
        check("occupancy", 32'(occupancy), 32'(exp_occ));
        check("busy", 32'(busy), 32'(exp_occ != 0));
        check("late_count", 32'(late_count), 32'(m_late));
        if (issue_valid) begin
          if (!seen) begin
            if (ri == wi) begin
              check("unexpected_issue", 32'(wi - ri), 32'd1);
            end else begin
              cur = rec[ri % SB];
              ri = ri + 1;
              check("fire_cycle", 32'(cyc), 32'(cur.edge_n));
            end
          end
          check("issue_t_start", 32'(issue_t_start), 32'(cur.t));
          check("issue_freq", 32'(issue_freq), 32'(cur.f));
          check("issue_phase", 32'(issue_phase), 32'(cur.p));
          check("issue_amp", 32'(issue_amp), 32'(cur.a));
          check("issue_late", 32'(issue_late), 32'(cur.late));
          seen = !(issue_ready && !flush);
        end else begin
          seen = 1'b0;
        end
      end
    end
    check("drain_timeout", 32'(timed_out), 32'd0);
    check("sb_leftover", 32'(wi - ri), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    counter = counter + 32'd1;
  endtask

  task automatic offer(input logic [31:0] inst);
    pin = inst;
    pin_valid = 1'b1;
    tick();
    pin_valid = 1'b0;
  endtask

  logic [15:0] rt;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    counter = 32'h0;
    issue_ready = 1'b1;

    // Due exactly on time
    offer(32'h0100_5A7F);
    repeat (16'h110) tick();

    // Late by 0x40
    counter = 32'h0000_0050;
    offer(32'h0010_3C21);
    repeat (8) tick();

    // Wait across the 16-bit wrap
    counter = 32'h1234_FFF0;
    offer(32'h0005_7E10);
    repeat (30) tick();

    // Fill under backpressure; sixth offer must be refused
    issue_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      offer({counter[15:0], 4'(i), 4'(i + 8), 8'(8'h40 + i)});
    end
    repeat (10) tick();
    issue_ready = 1'b1;
    repeat (20) tick();

    // Flush while firing with entries queued
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer({counter[15:0] - 16'd3, 4'hF, 4'(i), 8'(8'hA0 + i)});
    end
    repeat (4) tick();
    issue_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    issue_ready = 1'b0;
    repeat (4) tick();
    issue_ready = 1'b1;

    // Async reset while waiting
    offer({counter[15:0] + 16'd200, 16'h1234});
    offer({counter[15:0] + 16'd300, 16'h5678});
    repeat (4) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rt = counter[15:0] + 16'($urandom_range(0, 60)) - 16'd20;
      pin = {rt, 16'($urandom)};
      pin_valid = ($urandom_range(0, 1) == 1);
      issue_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 99) == 0);
      tick();
    end
    pin_valid = 1'b0;
    flush = 1'b0;
    issue_ready = 1'b1;

    for (int i = 0; i < 2000 && busy; i++) tick();
    timed_out = busy;
    repeat (3) tick();
    done = 1'b1;
    repeat (3) tick();
  end

endmodule
